// File: rtl/pre_if_stage_if.sv
// SRAM-like instruction fetch bus: one request/addr_ok handshake, then a data_ok beat.
interface pre_if_stage_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, wr, size, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave  (input req, wr, size, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/pre_if_stage.sv
// Pre-IF fetch engine: owns the next-fetch PC, runs one instruction fetch at a time
// and hands completed {adel, inst, pc} entries to IF through a 1-entry buffer.
//
// state  | meaning
// S_IDLE | no transaction outstanding; may issue a fetch or an address-error entry
// S_REQ  | request on the bus, address held until addr_ok
// S_WAIT | request accepted, waiting for data_ok
module pre_if_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter logic [31:0] EX_ENTRY = 32'hbfc00380
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [33:0]           br_bus_i,
  input  logic                  ws_ex_i,
  input  logic                  eret_i,
  input  logic [31:0]           cp0_epc_i,
  input  logic                  fs_allowin_i,
  output logic                  ps_to_fs_valid_o,
  output logic [64:0]           ps_to_fs_bus_o,
  pre_if_stage_if.master        inst_sram
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      state_q;
  logic        req_q;
  logic [31:0] pc_q;
  logic [31:0] req_addr_q;
  logic        cancel_q;
  logic        buf_valid_q;
  logic [64:0] buf_q;

  logic        br_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        buf_free;
  logic        issue;

  assign {br_stall, br_taken, br_target} = br_bus_i;

  always_comb begin
    redirect    = ws_ex_i | eret_i | br_taken;
    redirect_pc = br_target;
    if (ws_ex_i)     redirect_pc = EX_ENTRY;
    else if (eret_i) redirect_pc = cp0_epc_i;
  end

  // The buffer can take a new entry if it is empty or IF drains it this cycle.
  assign buf_free = ~buf_valid_q | fs_allowin_i;
  assign issue    = (state_q == S_IDLE) & ~br_stall & ~redirect & buf_free;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      cancel_q    <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_q       <= '0;
    end else begin
      if (fs_allowin_i || redirect) buf_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (issue) begin
            if (|pc_q[1:0]) begin
              buf_valid_q <= 1'b1;
              buf_q       <= {1'b1, 32'h0, pc_q};
            end else begin
              req_addr_q <= pc_q;
              req_q      <= 1'b1;
              state_q    <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (redirect) cancel_q <= 1'b1;
          if (inst_sram.addr_ok) begin
            req_q   <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (inst_sram.data_ok) begin
            state_q  <= S_IDLE;
            cancel_q <= 1'b0;
            // A redirect arriving with the data kills the word just like a pending cancel.
            if (~cancel_q && ~redirect && buf_free) begin
              buf_valid_q <= 1'b1;
              buf_q       <= {1'b0, inst_sram.rdata, req_addr_q};
              pc_q        <= req_addr_q + 32'd4;
            end
          end else if (redirect) begin
            cancel_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (redirect) pc_q <= redirect_pc;
    end
  end

  assign inst_sram.req   = req_q;
  assign inst_sram.wr    = 1'b0;
  assign inst_sram.size  = 2'b10;
  assign inst_sram.addr  = req_addr_q;
  assign inst_sram.wdata = 32'h0;

  assign ps_to_fs_valid_o = buf_valid_q;
  assign ps_to_fs_bus_o   = buf_q;

endmodule

// File: tb/tb_pre_if_stage.sv
// Directed bench for pre_if_stage: transaction-level reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_pre_if_stage;

  localparam logic [31:0] RESET_PC = 32'hbfc00000;
  localparam logic [31:0] EX_ENTRY = 32'hbfc00380;

  logic        clk = 1'b0;
  logic        reset;
  logic [33:0] br_bus;
  logic        ws_ex;
  logic        eret;
  logic [31:0] cp0_epc;
  logic        fs_allowin;
  logic        ps_to_fs_valid;
  logic [64:0] ps_to_fs_bus;

  pre_if_stage_if sram_if ();

  pre_if_stage dut (
    .clk              (clk),
    .reset            (reset),
    .br_bus_i         (br_bus),
    .ws_ex_i          (ws_ex),
    .eret_i           (eret),
    .cp0_epc_i        (cp0_epc),
    .fs_allowin_i     (fs_allowin),
    .ps_to_fs_valid_o (ps_to_fs_valid),
    .ps_to_fs_bus_o   (ps_to_fs_bus),
    .inst_sram        (sram_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fetch phase (0 none, 1 requesting, 2 awaiting data),
  // queue for the IF hand-off buffer.
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_raddr;
  bit          m_drop;
  bit          m_live = 0;
  logic [64:0] m_buf[$];

  always @(posedge clk) begin
    bit          redir;
    bit          had_room;
    logic [31:0] tgt;
    if (reset) begin
      m_phase = 0; m_pc = RESET_PC; m_raddr = RESET_PC; m_drop = 0;
      m_buf.delete();
      m_live = 1;
    end else begin
      redir = ws_ex || eret || br_bus[32];
      tgt   = ws_ex ? EX_ENTRY : (eret ? cp0_epc : br_bus[31:0]);
      had_room = (m_buf.size() == 0) || fs_allowin;
      if (fs_allowin && m_buf.size() != 0) void'(m_buf.pop_front());
      if (redir) m_buf.delete();
      if (m_phase == 0) begin
        if (!br_bus[33] && !redir && had_room) begin
          if (m_pc % 4 != 0) m_buf.push_back({1'b1, 32'h0, m_pc});
          else begin m_raddr = m_pc; m_phase = 1; end
        end
      end else if (m_phase == 1) begin
        if (redir) m_drop = 1;
        if (sram_if.addr_ok) m_phase = 2;
      end else begin
        if (sram_if.data_ok) begin
          if (!m_drop && !redir) begin
            m_buf.push_back({1'b0, sram_if.rdata, m_raddr});
            m_pc = m_raddr + 4;
          end
          m_drop = 0; m_phase = 0;
        end else if (redir) m_drop = 1;
      end
      if (redir) m_pc = tgt;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("m_req",   sram_if.req, m_phase == 1);
      chk("m_addr",  sram_if.addr, m_raddr);
      chk("m_valid", ps_to_fs_valid, m_buf.size() != 0);
      if (m_buf.size() != 0) chk("m_bus", ps_to_fs_bus, m_buf[0]);
      chk("m_const", {sram_if.wr, sram_if.size, sram_if.wdata}, {1'b0, 2'b10, 32'h0});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; br_bus = '0; ws_ex = 0; eret = 0; cp0_epc = '0; fs_allowin = 0;
    sram_if.addr_ok = 0; sram_if.data_ok = 0; sram_if.rdata = '0;
    tick(); tick(); tick();
    chk("rst_req", sram_if.req, 1'b0);
    chk("rst_addr", sram_if.addr, RESET_PC);
    chk("rst_valid", ps_to_fs_valid, 1'b0);
    chk("rst_size", sram_if.size, 2'b10);
    reset = 1'b0;

    // T1: first fetch after reset
    tick();
    chk("t1_req", sram_if.req, 1'b1);
    chk("t1_addr", sram_if.addr, 32'hbfc00000);
    sram_if.addr_ok = 1; tick();
    sram_if.addr_ok = 0; sram_if.data_ok = 1; sram_if.rdata = 32'h24010001; tick();
    sram_if.data_ok = 0;
    chk("t1_valid", ps_to_fs_valid, 1'b1);
    chk("t1_bus", ps_to_fs_bus, {1'b0, 32'h24010001, 32'hbfc00000});
    fs_allowin = 1; tick();
    fs_allowin = 0;
    chk("t1_next_addr", sram_if.addr, 32'hbfc00004);
    chk("t1_next_req", sram_if.req, 1'b1);

    // T2: exception while waiting for data
    sram_if.addr_ok = 1; tick();
    sram_if.addr_ok = 0; ws_ex = 1; tick();
    ws_ex = 0; sram_if.data_ok = 1; sram_if.rdata = 32'hdeadbeef; tick();
    sram_if.data_ok = 0;
    chk("t2_dropped", ps_to_fs_valid, 1'b0);
    tick();
    chk("t2_req", sram_if.req, 1'b1);
    chk("t2_addr", sram_if.addr, 32'hbfc00380);
    sram_if.addr_ok = 1; tick();
    sram_if.addr_ok = 0; sram_if.data_ok = 1; sram_if.rdata = 32'h00000000; tick();
    sram_if.data_ok = 0;
    chk("t2_bus", ps_to_fs_bus, {1'b0, 32'h0, 32'hbfc00380});

    // T4: buffer full, IF stalled
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_req", sram_if.req, 1'b0);
      chk("t4_bus", ps_to_fs_bus, {1'b0, 32'h0, 32'hbfc00380});
    end
    fs_allowin = 1; tick();
    fs_allowin = 0;
    chk("t4_req_after", sram_if.req, 1'b1);
    chk("t4_addr", sram_if.addr, 32'hbfc00384);

    // T5: taken branch coincident with addr_ok
    br_bus = {1'b0, 1'b1, 32'hbfc00040}; sram_if.addr_ok = 1; tick();
    br_bus = '0; sram_if.addr_ok = 0; sram_if.data_ok = 1; sram_if.rdata = 32'h11111111; tick();
    sram_if.data_ok = 0;
    chk("t5_dropped", ps_to_fs_valid, 1'b0);
    tick();
    chk("t5_addr", sram_if.addr, 32'hbfc00040);
    sram_if.addr_ok = 1; tick();
    sram_if.addr_ok = 0; sram_if.data_ok = 1; sram_if.rdata = 32'h22222222; tick();
    sram_if.data_ok = 0;
    chk("t5_bus", ps_to_fs_bus, {1'b0, 32'h22222222, 32'hbfc00040});

    // T6: branch stall in IDLE
    br_bus = {1'b1, 1'b0, 32'h0}; fs_allowin = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_stall_req", sram_if.req, 1'b0);
    end
    br_bus = '0; tick();
    fs_allowin = 0;
    chk("t6_req", sram_if.req, 1'b1);
    chk("t6_addr", sram_if.addr, 32'hbfc00044);
    sram_if.addr_ok = 1; tick();
    sram_if.addr_ok = 0; sram_if.data_ok = 1; sram_if.rdata = 32'h33333333; tick();
    sram_if.data_ok = 0;
    chk("t6_bus", ps_to_fs_bus, {1'b0, 32'h33333333, 32'hbfc00044});

    // T3: eret to a misaligned address
    eret = 1; cp0_epc = 32'hbfc00102; tick();
    eret = 0;
    chk("t3_flush", ps_to_fs_valid, 1'b0);
    tick();
    chk("t3_valid", ps_to_fs_valid, 1'b1);
    chk("t3_bus", ps_to_fs_bus, {1'b1, 32'h0, 32'hbfc00102});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold_req", sram_if.req, 1'b0);
      chk("t3_hold_bus", ps_to_fs_bus, {1'b1, 32'h0, 32'hbfc00102});
    end
    fs_allowin = 1; tick();
    chk("t3_refill", ps_to_fs_valid, 1'b1);
    br_bus = {1'b0, 1'b1, 32'hbfc00000}; tick();
    br_bus = '0; fs_allowin = 0;
    chk("t3_br_flush", ps_to_fs_valid, 1'b0);
    tick();
    chk("t3_br_addr", sram_if.addr, 32'hbfc00000);

    // Reset in the middle of a request
    reset = 1; tick();
    reset = 0;
    chk("rst2_req", sram_if.req, 1'b0);
    chk("rst2_valid", ps_to_fs_valid, 1'b0);
    tick();
    chk("rst2_addr", sram_if.addr, RESET_PC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
